// File: rtl/wb_regfile.sv
// 32x32 pipeline register file with W-to-D write bypass and a ready/valid register dump port.
// Register 0 is hardwired to zero; dumps never stall pipeline writes.
module wb_regfile (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  A3W,
  input  logic [31:0] WDW,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  input  logic        DumpReq,
  output logic        DumpValid,
  input  logic        DumpReady,
  output logic [4:0]  DumpIdx,
  output logic [31:0] DumpData,
  output logic        DumpDone
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic        done_q, done_d;
  logic [31:0] regs_q [32];
  logic [31:0] dump_rd;

  // Register array; entry 0 is only ever cleared and is masked on every read path.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (A3W != 5'd0) begin
      regs_q[A3W] <= WDW;
    end
  end

  // A nonzero index equal to A3W implies A3W is nonzero, so the bypass needs no extra test.
  assign RD1     = (A1 == 5'd0)    ? '0 : (A1 == A3W)    ? WDW : regs_q[A1];
  assign RD2     = (A2 == 5'd0)    ? '0 : (A2 == A3W)    ? WDW : regs_q[A2];
  assign dump_rd = (idx_q == 5'd0) ? '0 : (idx_q == A3W) ? WDW : regs_q[idx_q];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (DumpReq) begin
          state_d = StSend;
          idx_d   = '0;
        end
      end
      StSend: begin
        if (DumpReady) begin
          if (idx_q == 5'd31) begin
            state_d = StIdle;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    DumpValid = (state_q == StSend);
    DumpIdx   = idx_q;
    DumpDone  = done_q;
    DumpData  = DumpValid ? dump_rd : '0;
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed read/write/bypass checks plus a
// scoreboard of expected dump beats popped on each accepted transfer.
module tb_wb_regfile;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [4:0]  A3W, A1, A2;
  logic [31:0] WDW;
  logic [31:0] RD1, RD2;
  logic        DumpReq, DumpValid, DumpReady, DumpDone;
  logic [4:0]  DumpIdx;
  logic [31:0] DumpData;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
  } beat_t;

  beat_t sb[$];
  int    checks = 0;
  int    passed = 0;

  wb_regfile dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .A3W       (A3W),
    .WDW       (WDW),
    .A1        (A1),
    .A2        (A2),
    .RD1       (RD1),
    .RD2       (RD2),
    .DumpReq   (DumpReq),
    .DumpValid (DumpValid),
    .DumpReady (DumpReady),
    .DumpIdx   (DumpIdx),
    .DumpData  (DumpData),
    .DumpDone  (DumpDone)
  );

  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Expected image: reg[i] = i*0x11 with reg[4] possibly overwritten.
  task automatic push_dump_image(input logic [31:0] r4);
    beat_t b;
    for (int i = 0; i < 32; i++) begin
      b.idx  = 5'(i);
      b.data = (i == 0) ? 32'h0 : (i == 4) ? r4 : 32'(i) * 32'h11;
      sb.push_back(b);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; A3W = '0; WDW = '0; A1 = '0; A2 = '0; DumpReq = 1'b0; DumpReady = 1'b0;
    tick();
    tick();
    Reset = 1'b0; A1 = 5'd5; A2 = 5'd31;
    settle();
    checks++;
    if (DumpValid !== 1'b0 || DumpIdx !== 5'd0 || DumpDone !== 1'b0) begin
      $display("FAIL reset_fsm: valid=%b idx=%0d done=%b, required 0/0/0",
               DumpValid, DumpIdx, DumpDone);
    end else passed++;
    checks++;
    if (DumpData !== 32'h0) $display("FAIL reset_dumpdata: got %h required 0", DumpData);
    else passed++;
    checks++;
    if (RD1 !== 32'h0 || RD2 !== 32'h0) begin
      $display("FAIL reset_regs: RD1=%h RD2=%h required 0/0", RD1, RD2);
    end else passed++;
  endtask

  task automatic test_write_read();
    A3W = 5'd5; WDW = 32'hDEADBEEF; A1 = '0; A2 = '0;
    tick();
    A3W = '0; WDW = 32'h0; A1 = 5'd5; A2 = 5'd0;
    settle();
    checks++;
    if (RD1 !== 32'hDEADBEEF) $display("FAIL write_read_rd1: got %h required deadbeef", RD1);
    else passed++;
    checks++;
    if (RD2 !== 32'h0) $display("FAIL write_read_rd2_zero: got %h required 0", RD2);
    else passed++;
  endtask

  task automatic test_bypass();
    A3W = 5'd7; WDW = 32'h12345678; A1 = 5'd7; A2 = 5'd7;
    settle();
    checks++;
    if (RD1 !== 32'h12345678 || RD2 !== 32'h12345678) begin
      $display("FAIL bypass_same_cycle: RD1=%h RD2=%h required 12345678", RD1, RD2);
    end else passed++;
    tick();
    A3W = '0; WDW = $urandom; A1 = 5'd0; A2 = 5'd7;
    settle();
    checks++;
    if (RD1 !== 32'h0) $display("FAIL bypass_r0: got %h required 0", RD1);
    else passed++;
    checks++;
    if (RD2 !== 32'h12345678) $display("FAIL bypass_array: got %h required 12345678", RD2);
    else passed++;
    // Bypass must override an older array value.
    A3W = 5'd5; WDW = 32'h0BADF00D; A1 = 5'd5;
    settle();
    checks++;
    if (RD1 !== 32'h0BADF00D) $display("FAIL bypass_override: got %h required 0badf00d", RD1);
    else passed++;
    tick();
    A3W = '0;
  endtask

  task automatic test_full_dump();
    beat_t exp;
    int done_cnt = 0, done_c = -1, last_c = -1;
    for (int i = 1; i < 32; i++) begin
      A3W = 5'(i); WDW = 32'(i) * 32'h11;
      tick();
    end
    A3W = '0;
    push_dump_image(32'h44);
    DumpReady = 1'b1; DumpReq = 1'b1;
    tick();
    DumpReq = 1'b0;
    for (int c = 0; c < 40; c++) begin
      settle();
      if (DumpDone) begin done_cnt++; done_c = c; end
      if (DumpValid && DumpReady) begin
        checks++;
        if (sb.size() == 0) $display("FAIL full_dump_beat: extra beat idx=%0d", DumpIdx);
        else begin
          exp = sb.pop_front();
          if (DumpIdx !== exp.idx || DumpData !== exp.data)
            $display("FAIL full_dump_beat: idx=%0d data=%h required idx=%0d data=%h",
                     DumpIdx, DumpData, exp.idx, exp.data);
          else passed++;
        end
        if (DumpIdx == 5'd31) last_c = c;
      end
      tick();
    end
    checks++;
    if (sb.size() != 0) $display("FAIL full_dump_count: %0d beats missing, required 0", sb.size());
    else passed++;
    checks++;
    if (done_cnt != 1 || done_c != last_c + 1 || last_c != 31)
      $display("FAIL full_dump_done: pulses=%0d at cycle %0d last beat %0d, required 1 at 32 after 31",
               done_cnt, done_c, last_c);
    else passed++;
    sb.delete();
  endtask

  task automatic test_backpressure();
    beat_t exp;
    int stall = 0, done_cnt = 0;
    push_dump_image(32'h44);
    DumpReady = 1'b1; DumpReq = 1'b1;
    tick();
    DumpReq = 1'b0;
    for (int c = 0; c < 50; c++) begin
      DumpReady = !(DumpValid && DumpIdx == 5'd10 && stall < 3);
      settle();
      if (!DumpReady) begin
        stall++;
        checks++;
        if (DumpValid !== 1'b1 || DumpIdx !== 5'd10)
          $display("FAIL backpressure_hold: valid=%b idx=%0d required 1/10", DumpValid, DumpIdx);
        else passed++;
      end
      if (DumpDone) begin
        done_cnt++;
        // Request in the DumpDone cycle must start the next dump.
        DumpReq = 1'b1;
        tick();
        DumpReq = 1'b0;
        break;
      end
      if (DumpValid && DumpReady) begin
        checks++;
        if (sb.size() == 0) $display("FAIL backpressure_beat: extra beat idx=%0d", DumpIdx);
        else begin
          exp = sb.pop_front();
          if (DumpIdx !== exp.idx || DumpData !== exp.data)
            $display("FAIL backpressure_beat: idx=%0d data=%h required idx=%0d data=%h",
                     DumpIdx, DumpData, exp.idx, exp.data);
          else passed++;
        end
      end
      tick();
    end
    settle();
    checks++;
    if (sb.size() != 0 || stall != 3 || done_cnt != 1)
      $display("FAIL backpressure_totals: left=%0d stalls=%0d done=%0d required 0/3/1",
               sb.size(), stall, done_cnt);
    else passed++;
    checks++;
    if (DumpValid !== 1'b1 || DumpIdx !== 5'd0)
      $display("FAIL back_to_back_restart: valid=%b idx=%0d required 1/0", DumpValid, DumpIdx);
    else passed++;
    sb.delete();
  endtask

  // Continues the dump restarted at the end of test_backpressure.
  task automatic test_write_during_dump();
    beat_t exp;
    int stall = 0, done_cnt = 0;
    push_dump_image(32'h0000CAFE);
    for (int c = 0; c < 40; c++) begin
      if (DumpValid && DumpIdx == 5'd4 && stall < 3) begin
        DumpReady = 1'b0;
        if (stall == 0) begin A3W = 5'd4; WDW = 32'h0000CAFE; end
        else begin A3W = '0; WDW = $urandom; end
      end else begin
        DumpReady = 1'b1; A3W = '0;
      end
      settle();
      if (!DumpReady) begin
        stall++;
        checks++;
        if (DumpData !== 32'h0000CAFE || DumpIdx !== 5'd4)
          $display("FAIL write_during_dump: idx=%0d data=%h required idx=4 data=cafe",
                   DumpIdx, DumpData);
        else passed++;
      end
      if (DumpDone) done_cnt++;
      if (DumpValid && DumpReady) begin
        checks++;
        if (sb.size() == 0) $display("FAIL write_dump_beat: extra beat idx=%0d", DumpIdx);
        else begin
          exp = sb.pop_front();
          if (DumpIdx !== exp.idx || DumpData !== exp.data)
            $display("FAIL write_dump_beat: idx=%0d data=%h required idx=%0d data=%h",
                     DumpIdx, DumpData, exp.idx, exp.data);
          else passed++;
        end
      end
      tick();
    end
    A3W = '0;
    checks++;
    if (sb.size() != 0 || stall != 3 || done_cnt != 1)
      $display("FAIL write_dump_totals: left=%0d stalls=%0d done=%0d required 0/3/1",
               sb.size(), stall, done_cnt);
    else passed++;
    sb.delete();
  endtask

  task automatic test_reset_mid();
    int reached = 0, done_seen = 0;
    A3W = 5'd3; WDW = 32'h1; DumpReady = 1'b1;
    tick();
    A3W = '0; DumpReq = 1'b1;
    tick();
    DumpReq = 1'b0;
    for (int c = 0; c < 40; c++) begin
      settle();
      if (DumpValid && DumpIdx == 5'd20) begin reached = 1; break; end
      tick();
    end
    checks++;
    if (reached == 0) $display("FAIL reset_mid_reach: idx 20 not reached, last idx=%0d", DumpIdx);
    else passed++;
    // Reset wins over a simultaneous write and a pending transfer.
    Reset = 1'b1; A3W = 5'd9; WDW = 32'hFFFFFFFF;
    tick();
    Reset = 1'b0; A3W = '0; A1 = 5'd3; A2 = 5'd9;
    settle();
    checks++;
    if (DumpValid !== 1'b0 || DumpIdx !== 5'd0 || DumpDone !== 1'b0)
      $display("FAIL reset_mid_fsm: valid=%b idx=%0d done=%b required 0/0/0",
               DumpValid, DumpIdx, DumpDone);
    else passed++;
    checks++;
    if (RD1 !== 32'h0 || RD2 !== 32'h0)
      $display("FAIL reset_mid_regs: RD1=%h RD2=%h required 0/0", RD1, RD2);
    else passed++;
    for (int c = 0; c < 5; c++) begin
      if (DumpDone || DumpValid) done_seen++;
      tick();
    end
    checks++;
    if (done_seen != 0) $display("FAIL reset_mid_nodone: %0d active cycles, required 0", done_seen);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_full_dump();
    test_backpressure();
    test_write_during_dump();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 Clk  input  1  pipeline clock; all state SHALL update on the rising edge only.
REQ-003 Reset  input  1  synchronous, active-high reset; sampled on rising edge of Clk.
REQ-004 A3W  input  5  write-back destination register index from the W stage; 0 means no write.
REQ-005 WDW  input  32  write-back data from the W stage.
REQ-006 A1  input  5  read port 1 index (D stage rs).
REQ-007 A2  input  5  read port 2 index (D stage rt).
REQ-008 RD1  output  32  read port 1 data, combinational.
REQ-009 RD2  output  32  read port 2 data, combinational.
REQ-010 DumpReq  input  1  request a full register dump; level sampled in IDLE only.
REQ-011 DumpValid  output  1  dump beat valid.
REQ-012 DumpReady  input  1  consumer accepts the current dump beat.
REQ-013 DumpIdx  output  5  register index of the current dump beat.
REQ-014 DumpData  output  32  register value of the current dump beat, combinational.
REQ-015 DumpDone  output  1  one-cycle pulse after the final beat (index 31) is accepted.

Function
REQ-016 Storage SHALL be 32 x 32-bit registers; register 0 SHALL always read 0 and SHALL never be written.
REQ-017 Write: on a rising edge with Reset=0 and A3W!=0, reg[A3W] <= WDW; A3W=0 SHALL write nothing.
REQ-018 RD1 SHALL be 0 if A1=0; WDW if A1=A3W and A3W!=0 (same-cycle bypass); else reg[A1].
REQ-019 RD2 SHALL follow the same rule as REQ-018 using A2.
REQ-020 Read ports SHALL have zero-cycle latency; a value written at edge N SHALL be visible through bypass in the cycle before edge N and from the array after edge N.
REQ-021 The dump FSM SHALL have two states: IDLE and SEND.
REQ-022 IDLE: DumpValid=0; DumpReq=1 at an edge SHALL move the FSM to SEND with DumpIdx<=0.
REQ-023 SEND: DumpValid=1. A beat transfers at an edge where DumpValid=1 and DumpReady=1.
REQ-024 On a transfer with DumpIdx<31, DumpIdx SHALL increment by 1 and the FSM SHALL stay in SEND.
REQ-025 On a transfer with DumpIdx=31, the FSM SHALL return to IDLE, DumpIdx SHALL return to 0, and DumpDone SHALL be 1 for exactly the following cycle.
REQ-026 Without DumpReady, DumpIdx SHALL hold; DumpValid SHALL remain 1 (no withdrawal).
REQ-027 DumpData SHALL apply the REQ-018 rule using DumpIdx, so a same-cycle write to DumpIdx is reflected in that beat.
REQ-028 DumpReq SHALL be ignored while in SEND; a DumpReq high in the cycle DumpDone is high SHALL start a new dump.
REQ-029 Pipeline writes SHALL never be blocked or delayed by a dump in progress.
REQ-030 In IDLE, DumpIdx SHALL be 0 and DumpData SHALL equal 0.

Reset
REQ-031 On Reset=1 at an edge, all 32 registers SHALL clear to 0. The FSM SHALL go to IDLE with DumpIdx=0 and DumpDone=0.
REQ-032 Reset SHALL take priority over a simultaneous write and over a dump transfer.
REQ-033 A dump interrupted by Reset SHALL NOT emit DumpDone.

Verification
REQ-034 Write/read: write A3W=5, WDW=0xDEADBEEF, then set A3W=0 and A1=5 -> RD1=0xDEADBEEF; A2=0 -> RD2=0.
REQ-035 Bypass and $0: hold A3W=7, WDW=0x12345678 with A1=A2=7 in the same cycle -> RD1=RD2=0x12345678. Then A3W=0 with any WDW and A1=0 -> RD1=0.
REQ-036 Full dump: preload reg[i]=i*0x11 for i=1..31 and pulse DumpReq with DumpReady=1 -> 32 consecutive beats with idx 0..31 and data 0, 0x11, ..., 0x20F. DumpDone SHALL pulse once, the cycle after beat 31.
REQ-037 Backpressure: during a dump, drop DumpReady for 3 cycles at idx 10 -> DumpValid stays 1 and idx stays 10. No beat is skipped or duplicated.
REQ-038 Write during dump: at idx 4 with DumpReady=0, write reg[4]=0xCAFE -> DumpData=0xCAFE that cycle and on all later cycles of the beat.
REQ-039 Reset mid-operation: assert Reset at dump idx 20 after writing reg[3]=1 -> DumpValid=0, FSM in IDLE, no DumpDone, and RD1=0 for A1=3.
